// File: rtl/logic_op_engine.sv
// Clocked valid/ready engine for the 8-bit logic ops (AND/OR/XOR/NOT) with NZVC flags.
// Optional accumulator operand path is enabled by defining LOGIC_ENGINE_ACC_EN.
//
// state | meaning
// IDLE  | ready for a request, operands not yet captured
// EXEC  | operands captured, result and flags registered at the next edge
// RESP  | response valid and held until the consumer accepts it
module logic_op_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_A,
    input  logic [WIDTH-1:0] req_B,
    input  logic [1:0]       req_sel,
`ifdef LOGIC_ENGINE_ACC_EN
    input  logic             req_use_acc,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_NZVC,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_XOR = 2'b10;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       sel_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [3:0]       rsp_nzvc_q;
    logic [7:0]       op_count_q;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result_d;
    logic [3:0]       nzvc_d;

`ifdef LOGIC_ENGINE_ACC_EN
    logic [WIDTH-1:0] acc_q;
    logic             use_acc_q;

    assign op_a = use_acc_q ? acc_q : a_q;
`else
    assign op_a = a_q;
`endif

    always_comb begin
        result_d = '0;
        case (sel_q)
            SEL_AND: result_d = op_a & b_q;
            SEL_OR:  result_d = op_a | b_q;
            SEL_XOR: result_d = op_a ^ b_q;
            default: result_d = ~op_a;
        endcase
    end

    // Logic ops can never overflow or carry, so V and C are tied low.
    assign nzvc_d = {result_d[WIDTH-1], (result_d == '0), 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_nzvc_q   <= '0;
            op_count_q   <= '0;
`ifdef LOGIC_ENGINE_ACC_EN
            acc_q        <= '0;
            use_acc_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_q         <= req_A;
                        b_q         <= req_B;
                        sel_q       <= req_sel;
`ifdef LOGIC_ENGINE_ACC_EN
                        use_acc_q   <= req_use_acc;
`endif
                        req_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= result_d;
                    rsp_nzvc_q   <= nzvc_d;
`ifdef LOGIC_ENGINE_ACC_EN
                    acc_q        <= result_d;
`endif
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count_q  <= op_count_q + 8'd1;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_NZVC   = rsp_nzvc_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_logic_op_engine.sv
// Directed table-driven bench for logic_op_engine; accumulator cases run when LOGIC_ENGINE_ACC_EN is defined.
module tb_logic_op_engine;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_A;
    logic [7:0] req_B;
    logic [1:0] req_sel;
    logic       req_use_acc;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [3:0] rsp_NZVC;
    logic [7:0] op_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_cnt = 8'd0;

    logic_op_engine #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_A      (req_A),
        .req_B      (req_B),
        .req_sel    (req_sel),
`ifdef LOGIC_ENGINE_ACC_EN
        .req_use_acc(req_use_acc),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_NZVC   (rsp_NZVC),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] sel;
        logic [7:0] res;
        logic [3:0] nzvc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full request/response transaction; request fields are scrambled right after acceptance.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                          input logic use_acc, input logic [7:0] er, input logic [3:0] ef,
                          input bit chk, input string name);
        @(negedge clk);
        if (chk) check({name, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_A       = a;
        req_B       = b;
        req_sel     = sel;
        req_use_acc = use_acc;
        @(posedge clk); #1;
        req_valid   = 1'b0;
        req_A       = ~a;
        req_B       = ~b;
        req_sel     = sel ^ 2'b01;
        req_use_acc = ~use_acc;
        if (chk) begin
            check({name, " rsp_valid exec"}, {31'd0, rsp_valid}, 32'd0);
            check({name, " req_ready exec"}, {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        if (chk) begin
            check({name, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
            check({name, " result"}, {24'd0, rsp_result}, {24'd0, er});
            check({name, " nzvc"}, {28'd0, rsp_NZVC}, {28'd0, ef});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt   = exp_cnt + 8'd1;
        if (chk) begin
            check({name, " rsp_valid after hs"}, {31'd0, rsp_valid}, 32'd0);
            check({name, " req_ready after hs"}, {31'd0, req_ready}, 32'd1);
        end
        check({name, " op_count"}, {24'd0, op_count}, {24'd0, exp_cnt});
    endtask

    initial begin
        vecs[0] = '{a:8'h55, b:8'hAA, sel:2'b00, res:8'h00, nzvc:4'b0100};
        vecs[1] = '{a:8'h55, b:8'hAF, sel:2'b01, res:8'hFF, nzvc:4'b1000};
        vecs[2] = '{a:8'h55, b:8'hAF, sel:2'b10, res:8'hFA, nzvc:4'b1000};
        vecs[3] = '{a:8'h55, b:8'hFF, sel:2'b11, res:8'hAA, nzvc:4'b1000};
        vecs[4] = '{a:8'hF0, b:8'h8F, sel:2'b00, res:8'h80, nzvc:4'b1000};
        vecs[5] = '{a:8'h7F, b:8'h3F, sel:2'b00, res:8'h3F, nzvc:4'b0000};
        vecs[6] = '{a:8'h00, b:8'h00, sel:2'b01, res:8'h00, nzvc:4'b0100};
        vecs[7] = '{a:8'h3C, b:8'h3C, sel:2'b10, res:8'h00, nzvc:4'b0100};
        vecs[8] = '{a:8'hFF, b:8'h12, sel:2'b11, res:8'h00, nzvc:4'b0100};

        rst_n = 1'b0; req_valid = 1'b0; req_A = 8'h00; req_B = 8'h00;
        req_sel = 2'b00; req_use_acc = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset result", {24'd0, rsp_result}, 32'd0);
        check("reset nzvc", {28'd0, rsp_NZVC}, 32'd0);
        check("reset op_count", {24'd0, op_count}, 32'd0);

        // Reset while the engine is in EXEC: the operation must vanish.
        @(negedge clk);
        req_valid = 1'b1; req_A = 8'h55; req_B = 8'hAF; req_sel = 2'b01;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midop in exec", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midop rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midop rst req_ready", {31'd0, req_ready}, 32'd1);
        check("midop rst op_count", {24'd0, op_count}, 32'd0);
        check("midop rst result", {24'd0, rsp_result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midop no late rsp", {31'd0, rsp_valid}, 32'd0);
        check("midop no late count", {24'd0, op_count}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sel, 1'b0, vecs[i].res, vecs[i].nzvc, 1'b1,
                   $sformatf("vec%0d", i));
        end

        // Backpressure: hold the response 5 cycles, with a competing request pending.
        @(negedge clk);
        req_valid = 1'b1; req_A = 8'hC3; req_B = 8'h0F; req_sel = 2'b10;
        @(posedge clk); #1;
        req_A = 8'h11; req_B = 8'h22; req_sel = 2'b00;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp%0d result", k), {24'd0, rsp_result}, 32'h0000_00CC);
            check($sformatf("bp%0d nzvc", k), {28'd0, rsp_NZVC}, 32'h8);
            check($sformatf("bp%0d req_ready", k), {31'd0, req_ready}, 32'd0);
            check($sformatf("bp%0d op_count", k), {24'd0, op_count}, {24'd0, exp_cnt});
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check("bp release op_count", {24'd0, op_count}, {24'd0, exp_cnt});
        check("bp release req_ready", {31'd0, req_ready}, 32'd1);
        check("bp release rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        check("bp no spurious accept", {31'd0, req_ready}, 32'd1);

`ifdef LOGIC_ENGINE_ACC_EN
        run_op(8'h0F, 8'hF0, 2'b01, 1'b0, 8'hFF, 4'b1000, 1'b1, "acc or");
        run_op(8'h12, 8'h00, 2'b11, 1'b1, 8'h00, 4'b0100, 1'b1, "acc not");
        run_op(8'h99, 8'h5A, 2'b01, 1'b1, 8'h5A, 4'b0000, 1'b1, "acc chain or");
`endif

        // Fill op_count up to 255, then one more must wrap to 0.
        while (exp_cnt != 8'd255) begin
            run_op(8'hA5, 8'h0F, 2'b00, 1'b0, 8'h05, 4'b0000, 1'b0, "fill");
        end
        run_op(8'h80, 8'h01, 2'b10, 1'b0, 8'h81, 4'b1000, 1'b1, "wrap");
        check("wrap op_count zero", {24'd0, op_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logic_op_engine.md
# logic_op_engine

Sequential command/response engine for the 8-bit logic unit operations (AND, OR, XOR, NOT). It accepts one operation request on a valid/ready request port, registers operands and operation select, and computes result plus NZVC flags. It returns them on a valid/ready response port. It sits between a command source (sequencer, bus bridge or bench) and any consumer of logic results/flags, and provides the clocked, flow-controlled end of the logic-unit interface.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width in bits; N flag is bit `WIDTH-1`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  input  1  clock; all state changes on its rising edge.
  - `rst_n`  input  1  reset, asynchronous assert and active-low.
- Request port:
  - `req_valid`  input  1  request present.
  - `req_ready`  output  1  engine can accept a request.
  - `req_A`  input  WIDTH  operand A.
  - `req_B`  input  WIDTH  operand B; ignored for sel=11.
  - `req_sel`  input  2  operation: 00 A&B, 01 A|B, 10 A^B, 11 ~A.
  - `req_use_acc`  input  1  present only with `LOGIC_ENGINE_ACC_EN`; substitutes the accumulator for A.
- Response port:
  - `rsp_valid`  output  1  response present.
  - `rsp_ready`  input  1  consumer accepts the response.
  - `rsp_result`  output  WIDTH  operation result.
  - `rsp_NZVC`  output  4  flags {N,Z,V,C}.
- Status:
  - `op_count`  output  8  completed responses, modulo 256.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `req_ready`=1. On `req_valid`&`req_ready` it captures A, B, sel (and use_acc) and goes to EXEC.
- EXEC: `req_ready`=0. It computes the op on the captured operands, registers `rsp_result` and `rsp_NZVC`, and goes to RESP.
- RESP: `rsp_valid`=1 and `req_ready`=0. On `rsp_ready` it increments `op_count` and goes to IDLE. Otherwise it holds.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - V = 0 and C = 0 always; logic ops never overflow or carry.
- NOT (sel=11) ignores B entirely.
- `op_count` wraps 255 -> 0 without any flag.
- While `rsp_valid`=1, `rsp_result` and `rsp_NZVC` are stable until the response handshake completes.
- Request fields are sampled only at the accepting edge; later changes to `req_*` have no effect.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_result`=0, `rsp_NZVC`=4'b0000, `op_count`=0, accumulator=0.

## Timing
- Request handshake at edge E0 -> EXEC during cycle E0..E1 -> `rsp_valid`=1 from E1.
- Latency is 1 cycle from request acceptance to response valid.
- Response handshake at edge Ex -> `req_ready`=1 from Ex.
- Minimum spacing is 3 cycles per operation with `rsp_ready` held high.
- No new request is accepted in the cycle the response handshakes; `req_ready` is registered from state.
- `rsp_ready` asserted while `rsp_valid`=0 is ignored.
- `req_valid` asserted while `req_ready`=0 is ignored; the source must hold it.
- Reset asserted in any state returns all outputs immediately to their reset values. The in-flight operation is dropped and `op_count` is not incremented.

## Configuration
- Macro: `LOGIC_ENGINE_ACC_EN`.
- Defined:
  - Port `req_use_acc` exists.
  - A WIDTH-bit accumulator is loaded with the result at the EXEC edge of every operation.
  - When the captured `req_use_acc`=1, the accumulator value replaces `req_A` as operand A.
  - Back-to-back chaining sees the previous op's result.
- Undefined:
  - Port `req_use_acc` and the accumulator are absent.
  - Operand A is always `req_A`.

## Test plan
- AND, A=0x55 B=0xAA sel=00 -> `rsp_result`=0x00, `rsp_NZVC`=0100, `rsp_valid` one cycle after acceptance.
- OR, A=0x55 B=0xAF sel=01 -> 0xFF, NZVC=1000.
- XOR, A=0x55 B=0xAF sel=10 -> 0xFA, NZVC=1000.
- NOT, A=0x55 sel=11, B=0xFF -> 0xAA, NZVC=1000.
- Backpressure: `rsp_ready` held 0 for 5 cycles after `rsp_valid` -> result/flags stable, `req_ready`=0, `op_count` unchanged, then +1 on release.
- Reset mid-op: `rst_n` dropped while in EXEC -> `rsp_valid`=0 and `req_ready`=1 immediately, `op_count` unchanged.
- Wrap: `op_count` at 255 plus one operation -> 0.
- With `LOGIC_ENGINE_ACC_EN`:
  - First, OR 0x0F|0xF0 -> 0xFF.
  - Then NOT with `req_use_acc`=1 and `req_A`=0x12 -> 0x00, NZVC=0100.
